// File: rtl/datapath_mc_pkg.sv
// Shared types and constants for the multi-cycle datapath.
package datapath_mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  localparam logic [2:0] F3_EQ  = 3'b000;
  localparam logic [2:0] F3_NE  = 3'b001;
  localparam logic [2:0] F3_LT  = 3'b100;
  localparam logic [2:0] F3_GE  = 3'b101;
  localparam logic [2:0] F3_LTU = 3'b110;
  localparam logic [2:0] F3_GEU = 3'b111;

  localparam int PC_INC = 4;

  typedef struct packed {
    logic eq;
    logic ne;
    logic lt;
    logic ge;
    logic ltu;
    logic geu;
  } flags_t;

  // Picks the branch condition; the two unused encodings never branch.
  function automatic logic sel_flag(input logic [2:0] f3, input flags_t f);
    logic v;
    case (f3)
      F3_EQ:   v = f.eq;
      F3_NE:   v = f.ne;
      F3_LT:   v = f.lt;
      F3_GE:   v = f.ge;
      F3_LTU:  v = f.ltu;
      F3_GEU:  v = f.geu;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/datapath_mc_alu_flags.sv
// Adder/subtractor with comparison flags of A against the second operand.
module alu_flags
  import datapath_mc_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_sub,
  output logic [XLEN-1:0] o_sum,
  output flags_t          o_flags
);

  // Sum/difference and the six compare flags, all combinational.
  always_comb begin
    o_sum       = i_sub ? (i_a - i_b) : (i_a + i_b);
    o_flags.eq  = (i_a == i_b);
    o_flags.ne  = (i_a != i_b);
    o_flags.lt  = ($signed(i_a) <  $signed(i_b));
    o_flags.ge  = ($signed(i_a) >= $signed(i_b));
    o_flags.ltu = (i_a <  i_b);
    o_flags.geu = (i_a >= i_b);
  end

endmodule

// File: rtl/datapath_mc.sv
// Multi-cycle datapath: one operation per start, five states per operation.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; operands and controls captured on accept
// ST_READ | register file read into A and B
// ST_EXEC | ALU result and compare flags latched
// ST_MEM  | memory read into MDR, optional store of B, branch decision
// ST_WB   | done pulse, register write-back, pc update
module datapath_mc
  import datapath_mc_pkg::*;
#(
  parameter int               XLEN     = 64,
  parameter int               NREGS    = 32,
  parameter int               MEM_AW   = 8,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  localparam int              RW       = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] immediate,
  input  logic [RW-1:0]   rs1,
  input  logic [RW-1:0]   rs2,
  input  logic [RW-1:0]   rd,
  input  logic [2:0]      funct3,
  input  logic            mem_write,
  input  logic            reg_write,
  input  logic            wb_sel_mem,
  input  logic            b_sel_imm,
  input  logic            sub,
  input  logic            is_branch,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] pc,
  output logic            branch_taken
);

  state_t            r_state;
  logic [XLEN-1:0]   r_imm;
  logic [RW-1:0]     r_rs1;
  logic [RW-1:0]     r_rs2;
  logic [RW-1:0]     r_rd;
  logic [2:0]        r_funct3;
  logic              r_mem_write;
  logic              r_reg_write;
  logic              r_wb_sel_mem;
  logic              r_b_sel_imm;
  logic              r_sub;
  logic              r_is_branch;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_result;
  flags_t            r_flags;
  logic [XLEN-1:0]   r_mdr;
  logic [XLEN-1:0]   r_pc;
  logic              r_busy;
  logic              r_done;
  logic              r_branch_taken;
  logic [XLEN-1:0]   r_regs [NREGS];
  logic [XLEN-1:0]   r_mem  [2**MEM_AW];

  logic [XLEN-1:0]   w_op2;
  logic [XLEN-1:0]   w_sum;
  flags_t            w_flags;
  logic [MEM_AW-1:0] w_mem_addr;
  logic [XLEN-1:0]   w_rdata_a;
  logic [XLEN-1:0]   w_rdata_b;

  assign w_op2      = r_b_sel_imm ? r_imm : r_b;
  assign w_mem_addr = r_result[MEM_AW-1:0];
  assign w_rdata_a  = (r_rs1 == '0) ? '0 : r_regs[r_rs1];
  assign w_rdata_b  = (r_rs2 == '0) ? '0 : r_regs[r_rs2];

  alu_flags #(.XLEN(XLEN)) u_alu (
    .i_a     (r_a),
    .i_b     (w_op2),
    .i_sub   (r_sub),
    .o_sum   (w_sum),
    .o_flags (w_flags)
  );

  // Sequencer, register file and all registered outputs; reset wins over any write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_pc           <= RESET_PC;
      r_result       <= '0;
      r_branch_taken <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_imm        <= immediate;
            r_rs1        <= rs1;
            r_rs2        <= rs2;
            r_rd         <= rd;
            r_funct3     <= funct3;
            r_mem_write  <= mem_write;
            r_reg_write  <= reg_write;
            r_wb_sel_mem <= wb_sel_mem;
            r_b_sel_imm  <= b_sel_imm;
            r_sub        <= sub;
            r_is_branch  <= is_branch;
            r_busy       <= 1'b1;
            r_state      <= ST_READ;
          end
        end
        ST_READ: begin
          r_a     <= w_rdata_a;
          r_b     <= w_rdata_b;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_result <= w_sum;
          r_flags  <= w_flags;
          r_state  <= ST_MEM;
        end
        ST_MEM: begin
          // Non-blocking read here sees the pre-store contents.
          r_mdr          <= r_mem[w_mem_addr];
          r_branch_taken <= r_is_branch && sel_flag(r_funct3, r_flags);
          r_done         <= 1'b1;
          r_state        <= ST_WB;
        end
        ST_WB: begin
          if (r_reg_write && (r_rd != '0)) begin
            r_regs[r_rd] <= r_wb_sel_mem ? r_mdr : r_result;
          end
          r_pc    <= r_branch_taken ? (r_pc + r_imm) : (r_pc + XLEN'(PC_INC));
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Data memory store; contents survive reset but a reset cycle blocks the write.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == ST_MEM) && r_mem_write) begin
      r_mem[w_mem_addr] <= r_b;
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign result       = r_result;
  assign pc           = r_pc;
  assign branch_taken = r_branch_taken;

endmodule

// File: tb/tb_datapath_mc.sv
module tb_datapath_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] immediate;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic        mem_write, reg_write, wb_sel_mem, b_sel_imm, sub, is_branch;
  logic        busy, done, branch_taken;
  logic [63:0] result, pc;

  always #5 clk = ~clk;

  datapath_mc dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .immediate    (immediate),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .funct3       (funct3),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .wb_sel_mem   (wb_sel_mem),
    .b_sel_imm    (b_sel_imm),
    .sub          (sub),
    .is_branch    (is_branch),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .pc           (pc),
    .branch_taken (branch_taken)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [63:0] m_reg [32];
  logic [63:0] m_mem [256];
  logic [63:0] m_pc;

  logic [63:0] last_result;
  logic        last_taken;
  logic [63:0] last_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = '0;
  endtask

  task automatic model_op(input logic [63:0] imm, input logic [4:0] a1, a2, d,
                          input logic [2:0] f3, input logic mw, rw, wbm, bimm, sb, br,
                          output logic [63:0] eres, output logic etaken);
    logic [63:0] a, b, op2, mdr;
    logic        cond;
    a    = (a1 == 0) ? 64'd0 : m_reg[a1];
    b    = (a2 == 0) ? 64'd0 : m_reg[a2];
    op2  = bimm ? imm : b;
    eres = sb ? a - op2 : a + op2;
    case (f3)
      3'b000:  cond = (a == op2);
      3'b001:  cond = (a != op2);
      3'b100:  cond = ($signed(a) <  $signed(op2));
      3'b101:  cond = ($signed(a) >= $signed(op2));
      3'b110:  cond = (a <  op2);
      3'b111:  cond = (a >= op2);
      default: cond = 1'b0;
    endcase
    etaken = br && cond;
    mdr = m_mem[eres[7:0]];
    if (mw) m_mem[eres[7:0]] = b;
    if (rw && d != 0) m_reg[d] = wbm ? mdr : eres;
    m_pc = etaken ? m_pc + imm : m_pc + 64'd4;
  endtask

  task automatic set_fields(input logic [63:0] imm, input logic [4:0] a1, a2, d,
                            input logic [2:0] f3, input logic mw, rw, wbm, bimm, sb, br);
    immediate = imm; rs1 = a1; rs2 = a2; rd = d; funct3 = f3;
    mem_write = mw; reg_write = rw; wb_sel_mem = wbm; b_sel_imm = bimm; sub = sb; is_branch = br;
  endtask

  task automatic scramble();
    set_fields({$urandom, $urandom}, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic run_op(input logic [63:0] imm, input logic [4:0] a1, a2, d,
                        input logic [2:0] f3, input logic mw, rw, wbm, bimm, sb, br);
    logic [63:0] eres;
    logic        etaken;
    int          n;
    bit          got;
    model_op(imm, a1, a2, d, f3, mw, rw, wbm, bimm, sb, br, eres, etaken);
    @(negedge clk);
    set_fields(imm, a1, a2, d, f3, mw, rw, wbm, bimm, sb, br);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
    n = 0;
    got = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (done) got = 1;
      else chk("busy_mid", {63'd0, busy}, 64'd1);
    end
    chk("latency", 64'(n), 64'd4);
    if (got) begin
      chk("result", result, eres);
      chk("taken", {63'd0, branch_taken}, {63'd0, etaken});
      chk("busy_wb", {63'd0, busy}, 64'd1);
    end
    last_result = result;
    last_taken  = branch_taken;
    @(negedge clk);
    chk("pc", pc, m_pc);
    chk("busy_idle", {63'd0, busy}, 64'd0);
    chk("done_idle", {63'd0, done}, 64'd0);
    last_pc = pc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_pc", pc, 64'd0);
    chk("rst_taken", {63'd0, branch_taken}, 64'd0);
  endtask

  // Loads register r into result so it can be compared.
  task automatic read_reg(input logic [4:0] r);
    run_op(64'd0, r, 5'd0, 5'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Writes an immediate value into register r.
  task automatic set_reg(input logic [4:0] r, input logic [63:0] v);
    run_op(v, 5'd0, 5'd0, r, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int pulses, run, maxrun;
    logic [63:0] eres;
    logic        etaken;

    reset = 1'b1;
    start = 1'b0;
    set_fields('0, '0, '0, '0, '0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Give every memory word a known value.
    for (int i = 0; i < 256; i++)
      run_op(64'(i), 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Basic add-immediate after reset.
    do_reset();
    run_op(64'd5, 5'd0, 5'd0, 5'd3, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("first_result", last_result, 64'd5);
    chk("first_pc", last_pc, 64'd4);
    read_reg(5'd3);
    chk("x3", last_result, 64'd5);

    // Store then load.
    set_reg(5'd4, 64'h1234);
    run_op(64'd2, 5'd3, 5'd4, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(64'd2, 5'd3, 5'd0, 5'd5, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    read_reg(5'd5);
    chk("x5_load", last_result, 64'h1234);

    // Signed-less-than branch taken from pc 8.
    do_reset();
    set_reg(5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    set_reg(5'd2, 64'd1);
    chk("pc_before_br", last_pc, 64'd8);
    run_op(64'd16, 5'd1, 5'd2, 5'd0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("blt_taken", {63'd0, last_taken}, 64'd1);
    chk("blt_pc", last_pc, 64'd24);

    // Unsigned compare of the same operands falls through.
    do_reset();
    set_reg(5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    set_reg(5'd2, 64'd1);
    run_op(64'd16, 5'd1, 5'd2, 5'd0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bltu_taken", {63'd0, last_taken}, 64'd0);
    chk("bltu_pc", last_pc, 64'd12);

    // start held for ten cycles: two accepts, single-cycle done pulses, write to x0.
    @(negedge clk);
    set_fields(64'd7, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    pulses = 0; run = 0; maxrun = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) begin
        if (run == 0) pulses++;
        run++;
      end else run = 0;
      if (run > maxrun) maxrun = run;
    end
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) begin
        if (run == 0) pulses++;
        run++;
      end else run = 0;
      if (run > maxrun) maxrun = run;
    end
    model_op(64'd7, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, eres, etaken);
    model_op(64'd7, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, eres, etaken);
    chk("held_accepts", 64'(pulses), 64'd2);
    chk("held_pulse_len", 64'(maxrun), 64'd1);
    chk("held_pc", pc, m_pc);
    run_op(64'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("x0_zero", last_result, 64'd0);

    // Reset during the MEM state of a store aborts it.
    set_reg(5'd6, 64'hDEAD);
    @(negedge clk);
    set_fields(64'h10, 5'd0, 5'd6, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_pc", pc, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    reset = 1'b0;
    model_reset();
    run_op(64'h10, 5'd0, 5'd0, 5'd7, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    read_reg(5'd7);
    chk("abort_mem", last_result, 64'd0);

    // pc wrap and address truncation.
    run_op(64'hFFFF_FFFF_FFFF_FFFC - m_pc, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pc_top", last_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    set_reg(5'd8, 64'hCAFE);
    chk("pc_wrap", last_pc, 64'd0);
    run_op(64'h1FF, 5'd0, 5'd8, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(64'hFF, 5'd0, 5'd0, 5'd9, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    read_reg(5'd9);
    chk("addr_trunc", last_result, 64'hCAFE);

    // Random operations against the model.
    for (int k = 0; k < 80; k++) begin
      logic [63:0] imm;
      imm = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 300)) : {$urandom, $urandom};
      run_op(imm, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
